// File: rtl/common_word_serial_to_parallel_packer.sv
// Packs N_WORDS serial words into one word-major vector {wN-1..w0} with a one-cycle valid strobe.
// Optional sticky partial-discard flag: define COMMON_WORD_PACKER_DROP_FLAG_EN.
module common_word_serial_to_parallel_packer #(
  parameter int NB_SYMBOL        = 4,
  parameter int N_SYMBOLS_X_WORD = 3,
  parameter int N_WORDS          = 2
) (
  input  logic                                              i_clock,
  input  logic                                              i_reset,
  input  logic                                              i_valid,
  input  logic                                              i_sof,
  input  logic [NB_SYMBOL*N_SYMBOLS_X_WORD-1:0]             i_data,
`ifdef COMMON_WORD_PACKER_DROP_FLAG_EN
  input  logic                                              i_clear_error,
  output logic                                              o_drop_error,
`endif
  output logic [NB_SYMBOL*N_SYMBOLS_X_WORD*N_WORDS-1:0]     o_data_vector,
  output logic                                              o_valid
);

  localparam int NB_DATA   = NB_SYMBOL * N_SYMBOLS_X_WORD;
  localparam int NB_VECTOR = NB_DATA * N_WORDS;
  localparam int IDX_W     = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int SH_N      = (N_WORDS > 1) ? (N_WORDS - 1) : 1;
  localparam int SHADOW_W  = NB_DATA * SH_N;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);
  localparam bit SINGLE_WORD = (N_WORDS == 1);

  logic [IDX_W-1:0]     wr_idx_q, wr_idx_d;
  logic [SHADOW_W-1:0]  shadow_q, shadow_d;
  logic [NB_VECTOR-1:0] data_q,   data_d;
  logic                 valid_q,  valid_d;
  logic [NB_VECTOR-1:0] full_vec_s;

  // The final word completes the vector straight from the input, so no extra cycle is spent in the shadow.
  generate
    if (N_WORDS == 1) begin : g_single
      assign full_vec_s = i_data;
    end else begin : g_multi
      assign full_vec_s = {i_data, shadow_q[NB_DATA*(N_WORDS-1)-1:0]};
    end
  endgenerate

  // Next-state: word placement, vector completion and resynchronisation on i_sof.
  always_comb begin
    wr_idx_d = wr_idx_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    if (i_valid) begin
      if (i_sof) begin
        if (SINGLE_WORD) begin
          data_d   = full_vec_s;
          valid_d  = 1'b1;
          wr_idx_d = {IDX_W{1'b0}};
        end else begin
          shadow_d[NB_DATA-1:0] = i_data;
          wr_idx_d              = IDX_W'(1);
        end
      end else if (wr_idx_q == LAST_IDX) begin
        data_d   = full_vec_s;
        valid_d  = 1'b1;
        wr_idx_d = {IDX_W{1'b0}};
      end else begin
        for (int k = 0; k < SH_N; k++) begin
          if (wr_idx_q == IDX_W'(k)) begin
            shadow_d[k*NB_DATA +: NB_DATA] = i_data;
          end else begin
            shadow_d[k*NB_DATA +: NB_DATA] = shadow_q[k*NB_DATA +: NB_DATA];
          end
        end
        wr_idx_d = wr_idx_q + IDX_W'(1);
      end
    end else if (i_sof) begin
      wr_idx_d = {IDX_W{1'b0}};
    end else begin
      wr_idx_d = wr_idx_q;
    end
  end

  // State and output registers; reset dominates every input.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_idx_q <= {IDX_W{1'b0}};
      shadow_q <= {SHADOW_W{1'b0}};
      data_q   <= {NB_VECTOR{1'b0}};
      valid_q  <= 1'b0;
    end else begin
      wr_idx_q <= wr_idx_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  assign o_data_vector = data_q;
  assign o_valid       = valid_q;

`ifdef COMMON_WORD_PACKER_DROP_FLAG_EN
  logic drop_error_q, drop_error_d;
  logic discard_s;

  assign discard_s = i_sof && (wr_idx_q != {IDX_W{1'b0}});

  // Sticky discard flag; a discard in the same cycle as a clear keeps the flag set.
  always_comb begin
    drop_error_d = drop_error_q;
    if (discard_s) begin
      drop_error_d = 1'b1;
    end else if (i_clear_error) begin
      drop_error_d = 1'b0;
    end else begin
      drop_error_d = drop_error_q;
    end
  end

  // Flag register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      drop_error_q <= 1'b0;
    end else begin
      drop_error_q <= drop_error_d;
    end
  end

  assign o_drop_error = drop_error_q;
`endif

endmodule

// File: tb/tb_common_word_serial_to_parallel_packer.sv
// Scoreboard bench for the serial-to-parallel packer (12-bit words, 2 words per vector).
module tb_common_word_serial_to_parallel_packer;

  logic        clk;
  logic        i_reset;
  logic        i_valid;
  logic        i_sof;
  logic [11:0] i_data;
  logic [23:0] o_data_vector;
  logic        o_valid;
`ifdef COMMON_WORD_PACKER_DROP_FLAG_EN
  logic        i_clear_error;
  logic        o_drop_error;
`endif

  typedef struct {
    logic [23:0] vec;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  common_word_serial_to_parallel_packer #(
    .NB_SYMBOL       (4),
    .N_SYMBOLS_X_WORD(3),
    .N_WORDS         (2)
  ) dut (
    .i_clock      (clk),
    .i_reset      (i_reset),
    .i_valid      (i_valid),
    .i_sof        (i_sof),
    .i_data       (i_data),
`ifdef COMMON_WORD_PACKER_DROP_FLAG_EN
    .i_clear_error(i_clear_error),
    .o_drop_error (o_drop_error),
`endif
    .o_data_vector(o_data_vector),
    .o_valid      (o_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest expected vector at the expected cycle.
  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got vector 0x%0h expected no strobe (cycle %0d)", o_data_vector, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("vector", {8'h00, o_data_vector}, {8'h00, e.vec});
        chk("latency", cyc, e.cyc);
      end
    end
  end

  task automatic drv(input logic v, input logic s, input logic [11:0] d);
    @(negedge clk);
    i_valid = v;
    i_sof   = s;
    i_data  = d;
  endtask

  task automatic push(input logic [23:0] v);
    exp_t e;
    e.vec = v;
    e.cyc = cyc + 1;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1'b0, 1'b0, 12'h000);
  endtask

  initial begin
    i_reset = 1'b1;
    i_valid = 1'b0;
    i_sof   = 1'b0;
    i_data  = 12'h000;
`ifdef COMMON_WORD_PACKER_DROP_FLAG_EN
    i_clear_error = 1'b0;
`endif
    repeat (2) @(negedge clk);
    i_reset = 1'b0;

    // Reset then idle
    for (int i = 0; i < 10; i++) begin
      drv(1'b0, 1'b0, 12'h000);
      chk("idle_valid", {31'd0, o_valid}, 32'd0);
      chk("idle_vector", {8'h00, o_data_vector}, 32'd0);
`ifdef COMMON_WORD_PACKER_DROP_FLAG_EN
      chk("idle_drop", {31'd0, o_drop_error}, 32'd0);
`endif
    end

    // Basic pack, then hold
    drv(1'b1, 1'b0, 12'hABC);
    drv(1'b1, 1'b0, 12'h123);
    push(24'h123ABC);
    idle(3);
    chk("hold_vector", {8'h00, o_data_vector}, 32'h00123ABC);
    chk("hold_valid", {31'd0, o_valid}, 32'd0);

    // Streaming, no bubbles
    for (int w = 1; w <= 8; w++) begin
      drv(1'b1, 1'b0, 12'(w));
      if ((w % 2) == 0) push({12'(w), 12'(w - 1)});
    end
    idle(2);

    // Gaps
    drv(1'b1, 1'b0, 12'h111);
    idle(3);
    drv(1'b1, 1'b0, 12'h222);
    push(24'h222111);
    idle(2);

    // Resync: 0x555 is discarded
    drv(1'b1, 1'b1, 12'h555);
    drv(1'b1, 1'b1, 12'h777);
    drv(1'b1, 1'b0, 12'h888);
    push(24'h888777);
`ifdef COMMON_WORD_PACKER_DROP_FLAG_EN
    chk("drop_set", {31'd0, o_drop_error}, 32'd1);
    idle(2);
    chk("drop_sticky", {31'd0, o_drop_error}, 32'd1);
    @(negedge clk);
    i_clear_error = 1'b1;
    @(negedge clk);
    i_clear_error = 1'b0;
    chk("drop_clear", {31'd0, o_drop_error}, 32'd0);
    // Clear and discard together: set wins
    drv(1'b1, 1'b1, 12'h9A9);
    @(negedge clk);
    i_valid = 1'b0;
    i_sof = 1'b1;
    i_clear_error = 1'b1;
    @(negedge clk);
    i_sof = 1'b0;
    i_clear_error = 1'b0;
    chk("drop_set_wins", {31'd0, o_drop_error}, 32'd1);
    @(negedge clk);
    i_clear_error = 1'b1;
    @(negedge clk);
    i_clear_error = 1'b0;
`else
    idle(2);
`endif

    // Discard without data: sof alone realigns to slot 0
    drv(1'b1, 1'b0, 12'hAAA);
    drv(1'b0, 1'b1, 12'hFFF);
    drv(1'b1, 1'b0, 12'h333);
    drv(1'b1, 1'b0, 12'h444);
    push(24'h444333);
    idle(2);
`ifdef COMMON_WORD_PACKER_DROP_FLAG_EN
    @(negedge clk);
    i_clear_error = 1'b1;
    @(negedge clk);
    i_clear_error = 1'b0;
`endif

    // Reset mid-vector
    drv(1'b1, 1'b0, 12'h9AB);
    @(negedge clk);
    i_valid = 1'b0;
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    chk("reset_vector", {8'h00, o_data_vector}, 32'd0);
    chk("reset_valid", {31'd0, o_valid}, 32'd0);
    drv(1'b1, 1'b0, 12'h111);
    drv(1'b1, 1'b0, 12'h222);
    push(24'h222111);
    idle(3);
`ifdef COMMON_WORD_PACKER_DROP_FLAG_EN
    chk("reset_no_drop", {31'd0, o_drop_error}, 32'd0);
`endif
    chk("final_vector", {8'h00, o_data_vector}, 32'h00222111);
    chk("queue_drained", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
